// File: rtl/multdiv_issue.sv
// Issue/writeback sequencer for an external multiplier/divider: latches one
// instruction, pulses the unit, waits for its result (or a timeout), then writes back.
module multdiv_issue #(
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_isDiv,
    input  logic [31:0] issue_opA,
    input  logic [31:0] issue_opB,
    input  logic [4:0]  issue_rd,
    output logic        stall,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception,
    output logic        timeout,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             isdiv_q;
    logic [4:0]       rd_q;
    logic [31:0]      opa_q;
    logic [31:0]      opb_q;
    logic             at_limit;

    assign at_limit    = (count == CNT_W'(TIMEOUT_CYCLES - 1));
    assign md_operandA = opa_q;
    assign md_operandB = opb_q;
    assign wb_rd       = rd_q;
    assign dbg_state   = state;

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        wb_valid     = 1'b0;
        case (state)
            IDLE: begin
                stall = issue_valid;
                if (issue_valid) state_next = START;
            end
            START: begin
                stall        = 1'b1;
                md_ctrl_MULT = ~isdiv_q;
                md_ctrl_DIV  = isdiv_q;
                state_next   = WAIT;
            end
            WAIT: begin
                stall = 1'b1;
                if (md_resultRDY || at_limit) state_next = DONE;
            end
            DONE: begin
                // Pipeline advances here; a high issue_valid is the completing instruction.
                wb_valid   = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A reset cycle aborts everything, so nothing may escape combinationally.
        if (reset) begin
            stall        = 1'b0;
            md_ctrl_MULT = 1'b0;
            md_ctrl_DIV  = 1'b0;
            wb_valid     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            isdiv_q      <= 1'b0;
            rd_q         <= '0;
            opa_q        <= '0;
            opb_q        <= '0;
            wb_data      <= '0;
            wb_exception <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (issue_valid) begin
                        isdiv_q <= issue_isDiv;
                        rd_q    <= issue_rd;
                        opa_q   <= issue_opA;
                        opb_q   <= issue_opB;
                    end
                end
                START: count <= '0;
                WAIT: begin
                    count <= count + CNT_W'(1);
                    // A real result wins over a coincident timeout.
                    if (md_resultRDY) begin
                        wb_data      <= md_result;
                        wb_exception <= md_exception;
                        timeout      <= 1'b0;
                    end else if (at_limit) begin
                        wb_data      <= '0;
                        wb_exception <= 1'b1;
                        timeout      <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue: cycle-indexed scenarios with hand-computed
// expectations, sampled on the falling edge.
module tb_multdiv_issue;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic        issue_isDiv;
    logic [31:0] issue_opA;
    logic [31:0] issue_opB;
    logic [4:0]  issue_rd;
    logic        stall;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        md_ctrl_MULT;
    logic        md_ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        timeout;
    logic [1:0]  dbg_state;

    int vectors;
    int miscompares;

    multdiv_issue #(.TIMEOUT_CYCLES(40)) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_isDiv  (issue_isDiv),
        .issue_opA    (issue_opA),
        .issue_opB    (issue_opB),
        .issue_rd     (issue_rd),
        .stall        (stall),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .timeout      (timeout),
        .dbg_state    (dbg_state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_ctl(input string name, input int c, input logic [3:0] exp_ctl);
        logic [3:0] got_ctl;
        got_ctl = {stall, md_ctrl_MULT, md_ctrl_DIV, wb_valid};
        vectors++;
        if (got_ctl !== exp_ctl) begin
            miscompares++;
            $display("FAIL %s c=%0d {stall,mult,div,wb_valid} got=%b exp=%b", name, c, got_ctl, exp_ctl);
        end
    endtask

    task automatic check_wb(input string name, input int c, input logic [38:0] exp_wb);
        logic [38:0] got_wb;
        got_wb = {wb_rd, wb_data, wb_exception, timeout};
        vectors++;
        if (got_wb !== exp_wb) begin
            miscompares++;
            $display("FAIL %s c=%0d {rd,data,exc,timeout} got=%h exp=%h", name, c, got_wb, exp_wb);
        end
    endtask

    task automatic test_reset();
        logic [107:0] got;
        reset       = 1'b1;
        issue_valid = 1'b1;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            got = {stall, md_operandA, md_operandB, md_ctrl_MULT, md_ctrl_DIV, wb_valid,
                   wb_rd, wb_data, wb_exception, timeout, dbg_state};
            vectors++;
            if (got !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs c=%0d got=%h exp=0", c, got);
            end
            next_cycle();
        end
        reset       = 1'b0;
        issue_valid = 1'b0;
        @(negedge clock);
        check_ctl("reset_release", 0, 4'b0000);
        next_cycle();
    endtask

    task automatic test_mult();
        issue_isDiv = 1'b0; issue_opA = 32'd6; issue_opB = 32'd7; issue_rd = 5'd5;
        md_exception = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            issue_valid  = (c <= 19);
            // Stray ready in START and DONE must be ignored.
            md_resultRDY = (c == 1) || (c == 18) || (c == 19);
            md_result    = (c == 18) ? 32'd42 : 32'd999;
            @(negedge clock);
            check_ctl("mult_ctl", c, {c <= 18, c == 1, 1'b0, c == 19});
            if (c >= 19) check_wb("mult_wb", c, {5'd5, 32'd42, 1'b0, 1'b0});
            next_cycle();
        end
        md_resultRDY = 1'b0;
    endtask

    task automatic test_timeout();
        issue_isDiv = 1'b0; issue_opA = 32'd11; issue_opB = 32'd13; issue_rd = 5'd9;
        md_resultRDY = 1'b0; md_result = 32'h55; md_exception = 1'b0;
        for (int c = 0; c <= 43; c++) begin
            issue_valid = (c <= 42);
            @(negedge clock);
            check_ctl("timeout_ctl", c, {c <= 41, c == 1, 1'b0, c == 42});
            if (c == 42) check_wb("timeout_wb", c, {5'd9, 32'd0, 1'b1, 1'b1});
            next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        issue_isDiv = 1'b0; issue_opA = 32'd7; issue_opB = 32'd11; issue_rd = 5'd10;
        md_exception = 1'b0;
        for (int c = 0; c <= 43; c++) begin
            issue_valid  = (c <= 42);
            md_resultRDY = (c == 41);
            md_result    = (c == 41) ? 32'd77 : 32'd0;
            @(negedge clock);
            check_ctl("simul_ctl", c, {c <= 41, c == 1, 1'b0, c == 42});
            if (c == 42) check_wb("simul_wb", c, {5'd10, 32'd77, 1'b0, 1'b0});
            next_cycle();
        end
        md_resultRDY = 1'b0;
    endtask

    task automatic test_div();
        issue_isDiv = 1'b1; issue_opA = 32'd100; issue_opB = 32'd0; issue_rd = 5'd3;
        for (int c = 0; c <= 7; c++) begin
            issue_valid  = (c <= 6);
            md_resultRDY = (c == 5);
            md_exception = (c == 5);
            md_result    = 32'd0;
            @(negedge clock);
            check_ctl("div_ctl", c, {c <= 5, 1'b0, c == 1, c == 6});
            if (c == 1) begin
                vectors++;
                if ({md_operandA, md_operandB} !== {32'd100, 32'd0}) begin
                    miscompares++;
                    $display("FAIL div_operands got=%h/%h exp=64/0", md_operandA, md_operandB);
                end
            end
            if (c == 6) check_wb("div_wb", c, {5'd3, 32'd0, 1'b1, 1'b0});
            next_cycle();
        end
        md_resultRDY = 1'b0; md_exception = 1'b0; issue_isDiv = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        issue_isDiv = 1'b0; md_exception = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            issue_valid  = (c <= 10);
            issue_opA    = (c <= 5) ? 32'd3 : 32'd5;
            issue_opB    = (c <= 5) ? 32'd4 : 32'd5;
            issue_rd     = (c <= 5) ? 5'd1 : 5'd2;
            md_resultRDY = (c == 4) || (c == 9);
            md_result    = (c == 4) ? 32'd12 : (c == 9) ? 32'd25 : 32'd0;
            @(negedge clock);
            if (md_ctrl_MULT) pulses++;
            check_ctl("b2b_ctl", c, {(c <= 4) || (c >= 6 && c <= 9), c == 1 || c == 7, 1'b0,
                                     c == 5 || c == 10});
            if (c == 5)  check_wb("b2b_wb1", c, {5'd1, 32'd12, 1'b0, 1'b0});
            if (c == 10) check_wb("b2b_wb2", c, {5'd2, 32'd25, 1'b0, 1'b0});
            if (c == 7) begin
                vectors++;
                if (md_operandA !== 32'd5) begin
                    miscompares++;
                    $display("FAIL b2b_operandA got=%0d exp=5", md_operandA);
                end
            end
            next_cycle();
        end
        md_resultRDY = 1'b0;
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL b2b_pulse_count got=%0d exp=2", pulses);
        end
    endtask

    task automatic test_operand_hold();
        issue_isDiv = 1'b0; issue_rd = 5'd4; md_exception = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            issue_valid  = (c <= 9);
            issue_opA    = (c < 3) ? 32'd6 : 32'd99;
            issue_opB    = (c < 3) ? 32'd7 : 32'd1;
            md_resultRDY = (c == 8);
            md_result    = 32'd42;
            @(negedge clock);
            if (c >= 1 && c <= 9) begin
                vectors++;
                if ({md_operandA, md_operandB} !== {32'd6, 32'd7}) begin
                    miscompares++;
                    $display("FAIL hold_operands c=%0d got=%0d/%0d exp=6/7", c, md_operandA, md_operandB);
                end
            end
            if (c == 9) check_wb("hold_wb", c, {5'd4, 32'd42, 1'b0, 1'b0});
            next_cycle();
        end
        md_resultRDY = 1'b0;
    endtask

    task automatic test_reset_abort();
        issue_isDiv = 1'b0; issue_opA = 32'd8; issue_opB = 32'd9; issue_rd = 5'd7;
        md_exception = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            issue_valid  = (c <= 5);
            reset        = (c == 6);
            md_resultRDY = (c == 8);
            md_result    = 32'd123;
            @(negedge clock);
            check_ctl("abort_ctl", c, (c <= 5) ? {1'b1, c == 1, 1'b0, 1'b0} : 4'b0000);
            if (c >= 7) begin
                check_wb("abort_wb", c, {5'd0, 32'd0, 1'b0, 1'b0});
                vectors++;
                if ({md_operandA, dbg_state} !== {32'd0, 2'd0}) begin
                    miscompares++;
                    $display("FAIL abort_state c=%0d got opA=%0d state=%0d exp 0/0", c, md_operandA, dbg_state);
                end
            end
            next_cycle();
        end
        reset = 1'b0; md_resultRDY = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1; issue_valid = 1'b0; issue_isDiv = 1'b0;
        issue_opA = '0; issue_opB = '0; issue_rd = '0;
        md_result = '0; md_exception = 1'b0; md_resultRDY = 1'b0;
        test_reset();
        test_mult();
        test_timeout();
        test_simultaneous();
        test_div();
        test_back_to_back();
        test_operand_hold();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multdiv_issue.md
MULTDIV_ISSUE -- requirements
Module: multdiv_issue

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 40: maximum WAIT-state cycles before an operation is forced to complete with an exception.
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 issue_valid  input  1  pipeline presents a mult/div instruction.
REQ-005 issue_isDiv  input  1  0 = multiply, 1 = divide.
REQ-006 issue_opA, issue_opB  input  32 each  source operands.
REQ-007 issue_rd  input  5  destination register number.
REQ-008 stall  output  1  freezes the upstream pipeline while an operation is outstanding.
REQ-009 md_operandA, md_operandB  output  32 each  operands to the multiplier/divider unit.
REQ-010 md_ctrl_MULT, md_ctrl_DIV  output  1 each  one-cycle start pulses to the multiplier/divider unit.
REQ-011 md_result  input  32  result from the unit.
REQ-012 md_exception  input  1  exception from the unit.
REQ-013 md_resultRDY  input  1  result-valid from the unit.
REQ-014 wb_valid  output  1  one-cycle writeback pulse.
REQ-015 wb_rd  output  5  writeback destination register.
REQ-016 wb_data  output  32  writeback value.
REQ-017 wb_exception  output  1  writeback exception flag.
REQ-018 timeout  output  1  set with wb_valid when completion was forced by TIMEOUT_CYCLES.

Function
REQ-019 The FSM SHALL have four states: IDLE, START, WAIT, DONE.
REQ-020 In IDLE with issue_valid=1, the block SHALL latch issue_opA, issue_opB, issue_isDiv and issue_rd, and SHALL go to START.
REQ-021 In START, the block SHALL assert exactly one of md_ctrl_MULT/md_ctrl_DIV, selected by the latched isDiv, for exactly one cycle; it SHALL clear the timeout counter and go to WAIT.
REQ-022 md_ctrl_MULT and md_ctrl_DIV SHALL be 0 in every state other than START and SHALL never both be 1.
REQ-023 md_operandA/B SHALL be driven from the latched registers and held constant from START until the next IDLE-state issue; issue_op* changes after latching SHALL have no effect.
REQ-024 In WAIT, the counter SHALL increment each cycle.
REQ-025 In WAIT, md_resultRDY=1 SHALL capture md_result into wb_data and md_exception into wb_exception, clear timeout, and go to DONE.
REQ-026 If the counter reaches TIMEOUT_CYCLES-1 in WAIT with md_resultRDY=0, the block SHALL set wb_data=0, wb_exception=1, timeout=1 and go to DONE.
REQ-027 When md_resultRDY=1 and the counter limit occur in the same cycle, md_resultRDY SHALL take priority (normal completion, timeout=0).
REQ-028 md_resultRDY SHALL be ignored in IDLE, START and DONE (stale ready from a prior operation).
REQ-029 In DONE, wb_valid SHALL be 1 for exactly one cycle with wb_rd = latched rd; the FSM SHALL then go to IDLE.
REQ-030 wb_data, wb_exception and timeout SHALL hold their last captured values until the next completion.
REQ-031 stall SHALL be combinational: 1 when (state=IDLE and issue_valid=1), state=START, or state=WAIT; otherwise 0.
REQ-032 stall SHALL be 0 in DONE, so the pipeline advances the completing instruction.
REQ-033 issue_valid in DONE SHALL be ignored; it belongs to the completing instruction.
REQ-034 Latency: with issue in cycle 0, the start pulse is in cycle 1; with md_resultRDY first seen in WAIT at cycle k, wb_valid is in cycle k+1.

Reset
REQ-035 When reset=1 at a rising edge: state SHALL become IDLE; counter, latched operands, rd and all outputs (wb_*, timeout, md_*) SHALL become 0.
REQ-036 stall SHALL be 0 while reset=1.
REQ-037 Reset in START, WAIT or DONE SHALL abort the operation with no wb_valid pulse; a later md_resultRDY from the aborted operation SHALL be ignored.

Verification
REQ-038 mult 6*7, rd=5, unit asserts RDY with 42 seventeen cycles after the pulse -> md_ctrl_MULT high only in cycle 1; stall high cycles 0..18; wb_valid in cycle 19 with wb_rd=5, wb_data=42, wb_exception=0.
REQ-039 div 100/0, unit returns exception=1, result=0 -> md_ctrl_DIV single pulse; wb_valid with wb_exception=1, wb_data=0, timeout=0.
REQ-040 mult with no RDY, TIMEOUT_CYCLES=40 -> wb_valid after 40 WAIT cycles with wb_data=0, wb_exception=1, timeout=1; stall 0 in DONE.
REQ-041 issue_valid held high across two back-to-back mults (3*4 then 5*5) -> exactly two start pulses; second pulse in the cycle after IDLE re-entry; results 12 then 25.
REQ-042 reset asserted in WAIT cycle 5, then RDY pulsed -> no wb_valid; stall=0; all md_ctrl=0.
REQ-043 issue_opA changed from 6 to 99 during WAIT -> md_operandA remains 6 until completion.
